// File: rtl/vedic_4bit.sv
// rtl/vedic_4bit.sv - 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier with registered product
//
// Modules in this file:
//   full_adder   : 1-bit full adder
//                  x, y, ci -> s, co
//   ripple_add4  : 4-bit ripple-carry adder built from full_adder, carry-in tied low
//                  x[3:0], y[3:0] -> s[3:0], co
//   vedic_2x2    : 2x2 vertical-and-crosswise multiplier (AND terms + two half adders)
//                  x[1:0], y[1:0] -> p[3:0]
//   vedic_4bit   : top; four 2x2 partial products combined by ripple adders,
//                  product captured on every rising clk edge
//                  clk        rising-edge clock
//                  rst        asynchronous active-high reset, clears c
//                  a[3:0]     unsigned multiplicand
//                  b[3:0]     unsigned multiplier
//                  c[7:0]     registered product a*b, one cycle latency

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] k;

  assign k[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (k[i]),
      .s  (s[i]),
      .co (k[i+1])
    );
  end

  assign co = k[4];
endmodule

module vedic_2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  logic m10;
  logic m01;
  logic m11;
  logic k1;

  assign m10 = x[1] & y[0];
  assign m01 = x[0] & y[1];
  assign m11 = x[1] & y[1];

  // Crosswise terms meet in the first half adder, its carry joins the
  // vertical upper term in the second half adder.
  assign p[0] = x[0] & y[0];
  assign p[1] = m10 ^ m01;
  assign k1   = m10 & m01;
  assign p[2] = m11 ^ k1;
  assign p[3] = m11 & k1;
endmodule

module vedic_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;

  logic [3:0] t1_s;
  logic       t1_co;
  logic [3:0] t2_s;
  logic       t2_co;
  logic       mid_co;

  logic [3:0] hi_y;
  logic [3:0] hi_s;
  logic [2:0] hi_k;

  logic [7:0] c_next;

  vedic_2x2 u_q0 (.x(a[1:0]), .y(b[1:0]), .p(q0));
  vedic_2x2 u_q1 (.x(a[3:2]), .y(b[1:0]), .p(q1));
  vedic_2x2 u_q2 (.x(a[1:0]), .y(b[3:2]), .p(q2));
  vedic_2x2 u_q3 (.x(a[3:2]), .y(b[3:2]), .p(q3));

  // Cross products share weight 4.
  ripple_add4 u_t1 (.x(q1), .y(q2), .s(t1_s), .co(t1_co));

  // Fold in the upper half of q0, also at weight 4.
  ripple_add4 u_t2 (.x({2'b00, q0[3:2]}), .y(t1_s), .s(t2_s), .co(t2_co));

  // Both carries land at weight 64. They are mutually exclusive: when t1
  // carries, its low nibble is at most 2, and adding q0[3:2] (at most 2)
  // cannot carry again. So an OR merges them without losing anything.
  assign mid_co = t1_co | t2_co;

  // Upper nibble (weight 16): q3 + t2_s[3:2] + 4*mid_co.
  assign hi_y = {1'b0, mid_co, t2_s[3:2]};

  for (genvar i = 0; i < 3; i++) begin : g_hi
    full_adder u_fa (
      .x  (q3[i]),
      .y  (hi_y[i]),
      .ci ((i == 0) ? 1'b0 : hi_k[(i == 0) ? 0 : i-1]),
      .s  (hi_s[i]),
      .co (hi_k[i])
    );
  end

  // The product never exceeds 225, so nothing carries out of bit 7 and the
  // top stage only needs its sum output.
  assign hi_s[3] = q3[3] ^ hi_y[3] ^ hi_k[2];

  assign c_next = {hi_s, t2_s[1:0], q0[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= 8'h00;
    end else begin
      c <= c_next;
    end
  end
endmodule

// File: tb/tb_vedic_4bit.sv
// tb/tb_vedic_4bit.sv - self-checking bench for vedic_4bit against an arithmetic reference

module tb_vedic_4bit;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] c;

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  vedic_4bit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // On each falling edge: check the product captured at the previous rising
  // edge, then present the next operand pair and queue its product.
  task automatic step(input logic [3:0] na, input logic [3:0] nb, input string tag);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check(tag, c, last_exp);
    end
    a = na;
    b = nb;
    exp_q.push_back(ref_mul(na, nb));
  endtask

  task automatic flush(input string tag);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check(tag, c, last_exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a = 4'd15;
    b = 4'd15;

    // Asynchronous reset with full-scale operands present.
    #1 rst = 1'b1;
    #1 check("reset_async", c, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", c, 8'h00);
    end
    rst = 1'b0;
    exp_q.push_back(ref_mul(4'd15, 4'd15));
    flush("reset_release_225");

    // Squares ramp with a mid-stream reset pulse at n=10.
    for (int n = 0; n < 16; n++) begin
      step(4'(n), 4'(n), "squares");
      if (n == 10) begin
        #1 rst = 1'b1;
        #1 check("midrst_async", c, 8'h00);
        #1 rst = 1'b0;
      end
    end
    flush("squares");

    // Directed asymmetric, zero and carry-stress pairs.
    step(4'd15, 4'd1,  "dir_15x1");
    step(4'd1,  4'd15, "dir_15x1");
    step(4'd0,  4'd15, "dir_1x15");
    step(4'd12, 4'd5,  "dir_0x15");
    step(4'd7,  4'd9,  "dir_12x5");
    step(4'd15, 4'd14, "dir_7x9");
    step(4'd11, 4'd13, "dir_15x14");
    flush("dir_11x13");

    // Operands changing between edges must not disturb the held product.
    a = 4'd3;
    b = 4'd5;
    #2 check("hold_between_edges", c, last_exp);
    a = 4'd9;
    #1 check("hold_between_edges2", c, last_exp);

    // Randomized pairs.
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
    end
    flush("random");

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++) begin
      step(4'(i >> 4), 4'(i & 15), "exhaustive");
    end
    flush("exhaustive");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
